// File: rtl/qq_pkg.sv
// Shared definitions for the QuickQ sorted-array priority queue controller.
// Holds the default key width and depth and the controller state type.
`timescale 1ns/1ps
package qq_pkg;

  localparam int QQ_KW    = 16;
  localparam int QQ_DEPTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENQ_LOAD = 3'd1,
    ST_ENQ_SCAN = 3'd2,
    ST_ENQ_FILL = 3'd3,
    ST_DONE     = 3'd4
  } qq_state_t;

endpackage

// File: rtl/qq_sort_ctrl.sv
// Sequencing controller for the QuickQ sorted-array priority queue.
// Keys are held in descending order in an external array (index 0 largest),
// so the minimum always sits at count-1 and pops in one cycle. Enqueue runs
// an insertion-sort shift loop from the tail, walking an external pointer
// counter down with load/decrement strobes.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   flush                     abort and empty the queue
//   enq_valid/enq_key/enq_ready   enqueue handshake
//   deq_valid/deq_ready/deq_key   dequeue handshake, key valid with done
//   done                      one-cycle completion pulse
//   full, empty               occupancy flags
//   array_cnt_*               strobes to the pointer counter
//   last_index                count-1 (0 when empty), load value for the counter
//   pointer_next              pointer counter output
//   array_rd_addr/array_rd_data   combinational array read
//   array_we/array_wr_addr/array_wr_data  array write
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | accept requests; read address parked on the tail entry
// ENQ_LOAD    | wait for the pointer counter to load count-1
// ENQ_SCAN    | compare entry at pointer with new key, shift or place
// ENQ_FILL    | place new key at index 0
// DONE        | pulse done, return to IDLE
`timescale 1ns/1ps
module qq_sort_ctrl
  import qq_pkg::*;
#(
  parameter int  KW    = QQ_KW,
  parameter int  DEPTH = QQ_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          enq_valid,
  input  logic [KW-1:0] enq_key,
  output logic          enq_ready,
  input  logic          deq_valid,
  output logic          deq_ready,
  output logic [KW-1:0] deq_key,
  output logic          done,
  output logic          full,
  output logic          empty,
  output logic          array_cnt_ld,
  output logic          array_cnt_clr,
  output logic          array_cnt_decr,
  output logic          array_cnt_inc,
  output logic [31:0]   last_index,
  input  logic [31:0]   pointer_next,
  output logic [AW-1:0] array_rd_addr,
  input  logic [KW-1:0] array_rd_data,
  output logic          array_we,
  output logic [AW-1:0] array_wr_addr,
  output logic [KW-1:0] array_wr_data
);

  qq_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] deq_key_q, deq_key_d;

  logic          in_idle;
  logic          deq_fire;
  logic          enq_fire;
  logic [AW-1:0] ptr;

  assign in_idle   = (state_q == ST_IDLE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign deq_ready = in_idle && !empty && !flush;
  // Dequeue wins whenever both are requested against a non-empty queue.
  assign enq_ready = in_idle && !full && !flush && !(deq_valid && !empty);
  assign deq_fire  = deq_valid && deq_ready;
  assign enq_fire  = enq_valid && enq_ready;

  assign ptr            = pointer_next[AW-1:0];
  assign last_index     = empty ? 32'd0 : 32'(count_q - CW'(1));
  assign array_cnt_clr  = flush;
  assign array_cnt_inc  = 1'b0;
  assign done           = (state_q == ST_DONE);
  assign deq_key        = deq_key_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    k_d            = k_q;
    deq_key_d      = deq_key_q;
    array_rd_addr  = AW'(count_q - CW'(1));
    array_we       = 1'b0;
    array_wr_addr  = '0;
    array_wr_data  = '0;
    array_cnt_ld   = 1'b0;
    array_cnt_decr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (deq_fire) begin
          deq_key_d = array_rd_data;
          count_d   = count_q - CW'(1);
          state_d   = ST_DONE;
        end else if (enq_fire) begin
          k_d          = enq_key;
          array_cnt_ld = 1'b1;
          state_d      = empty ? ST_ENQ_FILL : ST_ENQ_LOAD;
        end
      end
      ST_ENQ_LOAD: state_d = ST_ENQ_SCAN;
      ST_ENQ_SCAN: begin
        array_rd_addr = ptr;
        array_we      = 1'b1;
        array_wr_addr = ptr + AW'(1);
        // Shift on equality so equal keys leave in arrival order.
        if (array_rd_data <= k_q) begin
          array_wr_data = array_rd_data;
          if (pointer_next == 32'd0) state_d = ST_ENQ_FILL;
          else array_cnt_decr = 1'b1;
        end else begin
          array_wr_data = k_q;
          count_d       = count_q + CW'(1);
          state_d       = ST_DONE;
        end
      end
      ST_ENQ_FILL: begin
        array_we      = 1'b1;
        array_wr_addr = '0;
        array_wr_data = k_q;
        count_d       = count_q + CW'(1);
        state_d       = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d        = ST_IDLE;
      count_d        = '0;
      array_we       = 1'b0;
      array_cnt_decr = 1'b0;
      array_cnt_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      k_q       <= '0;
      deq_key_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      k_q       <= k_d;
      deq_key_q <= deq_key_d;
    end
  end

endmodule
